// File: rtl/mmul_parallel_engine.sv
// rtl/mmul_parallel_engine.sv - 16-lane signed dot-product accumulator engine of the mmul_parallel HWPE
module mmul_parallel_engine #(
    parameter int NB_LANES   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_LEN    = 1024,
    parameter int CW         = $clog2(CNT_LEN) + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           test_mode_i,
    input  logic                           ctrl_clear_i,
    input  logic                           ctrl_enable_i,
    input  logic                           ctrl_start_i,
    input  logic [CW-1:0]                  ctrl_cnt_limit_i,
    input  logic [NB_LANES-1:0]            in1_valid_i,
    input  logic [NB_LANES*DATA_WIDTH-1:0] in1_data_i,
    output logic [NB_LANES-1:0]            in1_ready_o,
    input  logic [NB_LANES-1:0]            in2_valid_i,
    input  logic [NB_LANES*DATA_WIDTH-1:0] in2_data_i,
    output logic [NB_LANES-1:0]            in2_ready_o,
    output logic                           out_r_valid_o,
    output logic [DATA_WIDTH-1:0]          out_r_data_o,
    output logic [DATA_WIDTH/8-1:0]        out_r_strb_o,
    input  logic                           out_r_ready_i,
    output logic [CW-1:0]                  flags_cnt_o,
    output logic                           flags_done_o,
    output logic                           flags_idle_o,
    output logic                           flags_ready_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         limit_q, limit_d;
    logic                  done_q, done_d;

    logic                  all_valid;
    logic                  beat;
    logic [DATA_WIDTH-1:0] dot;
    logic                  unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign all_valid = (&in1_valid_i) && (&in2_valid_i);
    assign beat      = (state_q == ACC) && ctrl_enable_i && all_valid;

    // Products and the tree are kept at DATA_WIDTH: the low bits of a signed
    // product equal those of the unsigned one, so the wrap is two's complement.
    always_comb begin
        dot = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            dot = dot + in1_data_i[i*DATA_WIDTH +: DATA_WIDTH] * in2_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        if (ctrl_clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            limit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ctrl_start_i && ctrl_enable_i) begin
                        state_d = ACC;
                        limit_d = (ctrl_cnt_limit_i == '0) ? CW'(1) : ctrl_cnt_limit_i;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = acc_q + dot;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == limit_q) begin
                            state_d = EMIT;
                        end
                    end
                end
                EMIT: begin
                    // The sink may drain even while the engine is disabled.
                    if (out_r_ready_i) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    assign in1_ready_o   = {NB_LANES{beat}};
    assign in2_ready_o   = {NB_LANES{beat}};
    assign out_r_valid_o = (state_q == EMIT);
    assign out_r_data_o  = acc_q;
    assign out_r_strb_o  = {(DATA_WIDTH/8){out_r_valid_o}};
    assign flags_cnt_o   = cnt_q;
    assign flags_done_o  = done_q;
    assign flags_idle_o  = (state_q == IDLE);
    assign flags_ready_o = (state_q == ACC) && ctrl_enable_i;

endmodule

// File: tb/tb_mmul_parallel_engine.sv
// tb/tb_mmul_parallel_engine.sv - scoreboard bench for mmul_parallel_engine against a plain-arithmetic dot-product model
module tb_mmul_parallel_engine;
    localparam int NL = 16;
    localparam int DW = 32;
    localparam int CW = 11;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             test_mode, clear, enable, start;
    logic [CW-1:0]    cnt_limit;
    logic [NL-1:0]    in1_valid, in2_valid, in1_ready, in2_ready;
    logic [NL*DW-1:0] in1_data, in2_data;
    logic             out_valid, out_ready;
    logic [DW-1:0]    out_data;
    logic [DW/8-1:0]  out_strb;
    logic [CW-1:0]    f_cnt;
    logic             f_done, f_idle, f_ready;

    mmul_parallel_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
        .ctrl_clear_i(clear), .ctrl_enable_i(enable), .ctrl_start_i(start),
        .ctrl_cnt_limit_i(cnt_limit),
        .in1_valid_i(in1_valid), .in1_data_i(in1_data), .in1_ready_o(in1_ready),
        .in2_valid_i(in2_valid), .in2_data_i(in2_data), .in2_ready_o(in2_ready),
        .out_r_valid_o(out_valid), .out_r_data_o(out_data), .out_r_strb_o(out_strb),
        .out_r_ready_i(out_ready),
        .flags_cnt_o(f_cnt), .flags_done_o(f_done), .flags_idle_o(f_idle), .flags_ready_o(f_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] a_l[NL];
    logic [31:0] b_l[NL];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: signed dot product in wide arithmetic, keep low 32 bits.
    function automatic logic [31:0] ref_dot();
        longint s;
        s = 0;
        for (int i = 0; i < NL; i++) s += longint'($signed(a_l[i])) * longint'($signed(b_l[i]));
        return s[31:0];
    endfunction

    task automatic set_data(input int pat);
        for (int i = 0; i < NL; i++) begin
            case (pat)
                1: begin a_l[i] = 32'd1;          b_l[i] = 32'd2; end
                2: begin a_l[i] = 32'h7FFF_FFFF;  b_l[i] = 32'd2; end
                3: begin a_l[i] = (i == 0) ? -32'sd3 : 32'd0; b_l[i] = (i == 0) ? 32'd5 : 32'd0; end
                default: begin
                    a_l[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 20) - 10;
                    b_l[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 20) - 10;
                end
            endcase
            in1_data[i*DW +: DW] = a_l[i];
            in2_data[i*DW +: DW] = b_l[i];
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("strb", {60'd0, out_strb}, 64'hF);
            if (out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
                else begin
                    mon_exp = exp_q.pop_front();
                    check("result", {32'd0, out_data}, {32'd0, mon_exp});
                end
            end
        end
    end

    task automatic do_start(input int lim);
        @(posedge clk); #1;
        start = 1'b1; cnt_limit = lim[CW-1:0]; enable = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int lim, input int pat, input int stall_n,
                           input bit rstall, input bit en_mode, input int bp);
        int eff, beats, it;
        logic [31:0] acc;
        bit av, en;
        eff = (lim == 0) ? 1 : lim;
        do_start(lim);
        acc = 0; beats = 0; it = 0;
        while (beats < eff && it < 3000) begin
            set_data(pat);
            in1_valid = '1; in2_valid = '1;
            if (it < stall_n) in2_valid[7] = 1'b0;
            if (rstall && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) in1_valid[$urandom_range(0, NL-1)] = 1'b0;
                else in2_valid[$urandom_range(0, NL-1)] = 1'b0;
            end
            en = !(en_mode && it >= 2 && it < 6);
            enable = en;
            start = en_mode && (it == 1 || it == 7);
            cnt_limit = CW'($urandom_range(1, 3));
            av = (&in1_valid) && (&in2_valid);
            @(negedge clk);
            check("in1_ready", {48'd0, in1_ready}, {48'd0, {NL{av && en}}});
            check("in2_ready", {48'd0, in2_ready}, {48'd0, {NL{av && en}}});
            check("flags_ready", {63'd0, f_ready}, {63'd0, en});
            check("acc_cnt", {53'd0, f_cnt}, 64'(beats));
            check("acc_idle", {63'd0, f_idle}, 64'd0);
            check("acc_out_valid", {63'd0, out_valid}, 64'd0);
            if (av && en) begin
                acc = acc + ref_dot();
                beats++;
            end
            @(posedge clk); #1;
            it++;
        end
        if (beats < eff) check("job_timeout", 64'd0, 64'd1);
        if (stall_n == 0 && !rstall && !en_mode) check("beat_cycles", 64'(it), 64'(eff));
        start = 1'b0; enable = 1'b1; in1_valid = '0; in2_valid = '0;
        exp_q.push_back(acc);
        @(negedge clk);
        check("emit_valid", {63'd0, out_valid}, 64'd1);
        check("emit_cnt", {53'd0, f_cnt}, 64'(eff));
        for (int k = 0; k < bp; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data", {32'd0, out_data}, {32'd0, acc});
            check("bp_done", {63'd0, f_done}, 64'd0);
            check("bp_in_ready", {48'd0, in1_ready | in2_ready}, 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pre_done", {63'd0, f_done}, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", {63'd0, f_done}, 64'd1);
        check("post_idle", {63'd0, f_idle}, 64'd1);
        check("post_valid", {63'd0, out_valid}, 64'd0);
        check("post_cnt", {53'd0, f_cnt}, 64'(eff));
        @(posedge clk); #1;
        @(negedge clk);
        check("done_once", {63'd0, f_done}, 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_idle"}, {63'd0, f_idle}, 64'd1);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_data"}, {32'd0, out_data}, 64'd0);
        check({tag, "_cnt"}, {53'd0, f_cnt}, 64'd0);
        check({tag, "_done"}, {63'd0, f_done}, 64'd0);
        check({tag, "_fready"}, {63'd0, f_ready}, 64'd0);
        check({tag, "_ready"}, {48'd0, in1_ready | in2_ready}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; test_mode = 1'b0; clear = 1'b0; enable = 1'b1; start = 1'b0;
        cnt_limit = '0; in1_valid = '0; in2_valid = '0; in1_data = '0; in2_data = '0;
        out_ready = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;

        run_job(4, 1, 0, 1'b0, 1'b0, 0);
        run_job(2, 1, 3, 1'b0, 1'b0, 0);
        run_job(3, 0, 0, 1'b0, 1'b0, 5);
        run_job(1, 2, 0, 1'b0, 1'b0, 0);
        run_job(1, 3, 0, 1'b0, 1'b0, 1);

        // Clear after 3 of 8 beats, with a coincident start that must be dropped.
        do_start(8);
        set_data(0); in1_valid = '1; in2_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b1; start = 1'b1; cnt_limit = CW'(5);
        @(posedge clk); #1;
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        check_reset_state("clear");
        @(posedge clk); #1;
        @(negedge clk);
        check("clear_start_dropped", {63'd0, f_idle}, 64'd1);
        in1_valid = '0; in2_valid = '0;
        run_job(0, 0, 0, 1'b0, 1'b0, 0);

        run_job(10, 0, 0, 1'b0, 1'b1, 2);

        // Asynchronous reset mid-job: no partial result may appear.
        do_start(5);
        set_data(0); in1_valid = '1; in2_valid = '1;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async");
        @(negedge clk); in1_valid = '0; in2_valid = '0;
        @(negedge clk); rst_n = 1'b1;

        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 12), 0, 0, 1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/mmul_parallel_engine.md
Name: mmul_parallel_engine

Overview:
- Datapath engine of the mmul_parallel HWPE: the responder to the controller FSM's engine control port.
- Consumes 16 in1 lanes and 16 in2 lanes from the streamer sources.
- Each accepted beat yields the 16-lane dot product, accumulated over cnt_limit beats.
- Emits one 32-bit result on the out_r sink stream and reports progress and completion back to the FSM on the flags port.

Parameters:
- NB_LANES, 16, lanes per input stream (in1 and in2 each).
- DATA_WIDTH, 32, lane and result width in bits.
- CNT_LEN, 1024, maximum beats per accumulation; CW = $clog2(CNT_LEN)+1 = 11.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- test_mode_i  in  1  test mode; no functional effect.
- ctrl_clear_i  in  1  synchronous clear.
- ctrl_enable_i  in  1  engine enable; low freezes all state.
- ctrl_start_i  in  1  one-cycle job start.
- ctrl_cnt_limit_i  in  CW  beats to accumulate; sampled on start.
- in1_valid_i  in  NB_LANES  per-lane valid.
- in1_data_i  in  NB_LANES*DATA_WIDTH  lane i at bits [i*32 +: 32].
- in1_ready_o  out  NB_LANES  per-lane ready.
- in2_valid_i, in2_data_i, in2_ready_o  same widths and meaning as in1.
- out_r_valid_o  out  1  result valid.
- out_r_data_o  out  DATA_WIDTH  result.
- out_r_strb_o  out  DATA_WIDTH/8  byte strobe; all ones whenever valid.
- out_r_ready_i  in  1  sink ready.
- flags_cnt_o  out  CW  beats accepted in the current job.
- flags_done_o  out  1  one-cycle pulse, job complete.
- flags_idle_o  out  1  engine in IDLE.
- flags_ready_o  out  1  engine accepting input beats this cycle.

Behaviour:
- Reset (async, rst_ni low):
  - State IDLE; accumulator, cnt and limit register cleared to 0.
  - All *_ready_o, out_r_valid_o, flags_done_o and flags_cnt_o = 0; out_r_data_o = 0.
  - flags_idle_o = 1; flags_ready_o = 0.
- States: IDLE, ACC, EMIT.
- IDLE -> ACC on ctrl_start_i && ctrl_enable_i:
  - limit <= (cnt_limit == 0) ? 1 : cnt_limit.
  - acc <= 0; cnt <= 0.
- Start is ignored in ACC and EMIT.
- Beat handshake in ACC (enable high):
  - all_valid = &in1_valid_i && &in2_valid_i.
  - All 32 ready bits = all_valid, asserted together; no partial-lane consumption.
  - flags_ready_o = (state == ACC) && ctrl_enable_i.
  - A beat is accepted when all_valid is high in ACC with enable high.
- Accepted beat:
  - acc <= acc + sum over i of (in1[i] * in2[i]).
  - Operands are signed two's complement; each product is truncated to its low 32 bits.
  - Adder tree and accumulator wrap modulo 2^32; no saturation, no overflow flag.
  - cnt <= cnt + 1.
- ACC -> EMIT when the beat that makes cnt == limit is accepted:
  - out_r_valid_o rises the next cycle with out_r_data_o = final acc.
  - Latency from last input handshake to out_r_valid_o is 1 cycle.
- EMIT:
  - out_r_valid_o and out_r_data_o are held stable until out_r_ready_i is seen.
  - Input readys are 0.
  - On the out_r handshake: flags_done_o pulses for the next cycle only, state -> IDLE, out_r_valid_o -> 0.
  - flags_cnt_o holds limit until the next start.
- ctrl_enable_i low: no state, counter or accumulator updates; all input readys 0.
  - out_r_valid_o stays asserted if in EMIT. A handshake in EMIT still completes (sink may drain).
- ctrl_clear_i (highest priority, any state):
  - Next cycle state IDLE; acc, cnt and limit are 0; out_r_valid_o = 0; no done pulse.
  - A start coincident with clear is dropped.
- flags_idle_o = (state == IDLE).
- flags_cnt_o = registered cnt.
- Asynchronous reset mid-job: immediate return to reset values. No partial result is emitted.

Test Plan:
- Basic job: reset, start with cnt_limit = 4, all lanes in1 = 1 and in2 = 2, all valid each cycle.
  - Required: 4 beats accepted in 4 cycles; out_r_data_o = 128 one cycle after the 4th beat; done pulses once after out_r_ready_i; flags_idle_o returns to 1.
- Lane stall: cnt_limit = 2; in2 lane 7 valid low for 3 cycles.
  - Required: no ready asserted on any lane and cnt frozen during the stall; result unchanged vs. the no-stall run.
- Back-pressure: out_r_ready_i low for 5 cycles in EMIT.
  - Required: valid and data stable for all 5 cycles; done asserted only the cycle after ready rises.
- Arithmetic wrap: cnt_limit = 1; all lanes in1 = 0x7FFFFFFF, in2 = 2.
  - Required: out_r_data_o = 16 * 0xFFFFFFFE mod 2^32 = 0xFFFFFFE0.
  - Signed check: lane 0 in1 = -3, in2 = 5, others 0 -> 0xFFFFFFF1.
- Clear mid-job: cnt_limit = 8; assert clear after 3 beats.
  - Required: next cycle idle = 1, cnt = 0, no out_r_valid_o, no done.
  - A following start with cnt_limit = 0 accepts exactly 1 beat.
- Enable freeze and restart rules: deassert enable for 4 cycles mid-ACC, and pulse start during ACC.
  - Required: cnt and acc unchanged while enable is low; the mid-job start is ignored; the final result matches the uninterrupted reference.
